// File: rtl/sad_pkg.sv
// Shared constants and FSM state type for the SAD engine and its pipeline stages.
package sad_pkg;

  localparam int N_MAX     = 256;
  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 32;
  localparam int ACC_W     = 40;
  localparam int DRAIN_LEN = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/sad_engine_if.sv
// Control and ROM bundle between the SAD engine and whatever drives it.
// The master side issues start/len and also serves the combinational ROM data.
interface sad_engine_if;
  import sad_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data_a;
  logic [DATA_W-1:0] rom_data_b;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  sad;

  modport master (
    output start, len, rom_data_a, rom_data_b,
    input  rom_addr, busy, done, sad
  );

  modport slave (
    input  start, len, rom_data_a, rom_data_b,
    output rom_addr, busy, done, sad
  );

endinterface

// File: rtl/sad_absdiff.sv
// Registered absolute-difference stage: |a - b| of two signed words, one cycle latency.
module sad_absdiff
  import sad_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              valid_in,
  output logic [DATA_W-1:0] absdiff,
  output logic              valid_out
);

  logic signed [DATA_W:0] diff;
  logic [DATA_W-1:0]      absdiff_d;
  logic [DATA_W-1:0]      absdiff_q;
  logic                   valid_q;

  // One extra bit keeps the difference exact; its magnitude always fits in DATA_W bits.
  always_comb begin
    diff      = $signed({a[DATA_W-1], a}) - $signed({b[DATA_W-1], b});
    absdiff_d = diff[DATA_W] ? DATA_W'(-diff) : DATA_W'(diff);
  end

  // NOTE: only the valid bit is reset; the data word is qualified by it and needs no reset.
  always_ff @(posedge clk) begin
    absdiff_q <= absdiff_d;
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_in;
  end

  assign absdiff   = absdiff_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/sad_engine.sv
// Sum-of-absolute-differences engine: sweeps the dual-output ROM for L elements
// through a 3-stage pipeline (capture, |A-B|, accumulate) and pulses done with the result.
module sad_engine
  import sad_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  sad_engine_if.slave  bus
);

  state_e            state_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] len_clamped;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [1:0]        drain_q;
  logic              busy_q;
  logic              done_q;
  logic [ACC_W-1:0]  sad_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_d;

  logic [DATA_W-1:0] s1_a_q;
  logic [DATA_W-1:0] s1_b_q;
  logic              s1_valid_q;
  logic [DATA_W-1:0] s2_absdiff;
  logic              s2_valid;

  assign len_clamped = (bus.len > ADDR_W'(N_MAX)) ? ADDR_W'(N_MAX) : bus.len;

  always_comb begin
    acc_d = acc_q;
    if (s2_valid) acc_d = acc_q + ACC_W'(s2_absdiff);
  end

  always_ff @(posedge clk) begin
    s1_a_q <= bus.rom_data_a;
    s1_b_q <= bus.rom_data_b;
  end

  sad_absdiff u_absdiff (
    .clk       (clk),
    .rst       (rst),
    .a         (s1_a_q),
    .b         (s1_b_q),
    .valid_in  (s1_valid_q),
    .absdiff   (s2_absdiff),
    .valid_out (s2_valid)
  );

  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      rom_addr_q <= '0;
      drain_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sad_q      <= '0;
      acc_q      <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      acc_q      <= acc_d;
      s1_valid_q <= (state_q == RUN);
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            len_q      <= len_clamped;
            acc_q      <= '0;
            rom_addr_q <= '0;
            busy_q     <= 1'b1;
            if (len_clamped == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              sad_q   <= '0;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (rom_addr_q == len_q - ADDR_W'(1)) begin
            state_q    <= DRAIN;
            rom_addr_q <= '0;
            drain_q    <= '0;
          end else begin
            rom_addr_q <= rom_addr_q + ADDR_W'(1);
          end
        end
        DRAIN: begin
          // The last element reaches the accumulator on this edge, so publish acc_d.
          if (drain_q == 2'(DRAIN_LEN - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            sad_q   <= acc_d;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sad      = sad_q;

endmodule

// File: tb/tb_sad_engine.sv
// Self-checking bench for sad_engine: cycle-level behavioural model plus directed and random runs.
module tb_sad_engine;
  import sad_pkg::*;

  logic clk;
  logic rst;

  sad_engine_if bus ();

  sad_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DATA_W-1:0] mem_a [N_MAX];
  logic [DATA_W-1:0] mem_b [N_MAX];

  assign bus.rom_data_a = mem_a[bus.rom_addr[7:0]];
  assign bus.rom_data_b = mem_b[bus.rom_addr[7:0]];

  int     n_vec;
  int     n_fail;
  int     ecnt;
  bit     chk_en;

  // Model: a run accepted at edge E0 occupies cycles 1..m_end counted from E0.
  bit     m_act;
  int     m_e0;
  int     m_L;
  int     m_end;
  longint m_exp;
  longint m_hold;

  int     done_cnt;
  int     done_e;
  longint done_sad;
  int     max_addr;
  int     start_e;
  int     done_base;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, got, exp, ecnt);
    end
  endtask

  function automatic longint ref_sad(input int l);
    longint s = 0;
    for (int i = 0; i < l; i++) begin
      longint d = longint'($signed(mem_a[i])) - longint'($signed(mem_b[i]));
      s += (d < 0) ? -d : d;
    end
    return s;
  endfunction

  // Model update on each rising edge, from the inputs the DUT samples on that edge.
  initial forever begin
    bit was_idle;
    @(posedge clk);
    was_idle = !m_act;
    if (m_act && (ecnt - m_e0 + 1) == m_end) begin
      m_hold = m_exp;
      m_act  = 1'b0;
    end
    ecnt++;
    if (rst) begin
      m_act  = 1'b0;
      m_hold = 0;
    end else if (was_idle && bus.start) begin
      m_e0  = ecnt;
      m_L   = (int'(bus.len) > N_MAX) ? N_MAX : int'(bus.len);
      m_end = (m_L == 0) ? 1 : m_L + 3;
      m_exp = ref_sad(m_L);
      m_act = 1'b1;
    end
  end

  // Compare process: every cycle, mid-period.
  initial forever begin
    int k;
    bit exp_done;
    int exp_addr;
    @(negedge clk);
    if (chk_en) begin
      k        = ecnt - m_e0 + 1;
      exp_done = m_act && (k == m_end);
      exp_addr = (m_act && k <= m_L) ? k - 1 : 0;
      check("busy", 64'(bus.busy), 64'(m_act));
      check("done", 64'(bus.done), 64'(exp_done));
      check("rom_addr", 64'(bus.rom_addr), 64'(exp_addr));
      if (exp_done)    check("sad_at_done", 64'(bus.sad), 64'(m_exp));
      else if (!m_act) check("sad_hold", 64'(bus.sad), 64'(m_hold));
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_e   = ecnt;
      done_sad = longint'(bus.sad);
    end
    if (bus.busy === 1'b1 && int'(bus.rom_addr) > max_addr) max_addr = int'(bus.rom_addr);
  end

  task automatic pulse_start(input int l);
    @(negedge clk);
    done_base = done_cnt;
    bus.start = 1'b1;
    bus.len   = 9'(l);
    @(negedge clk);
    start_e   = ecnt;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int want, input int budget);
    for (int i = 0; i < budget && done_cnt < want; i++) @(negedge clk);
    check("done_seen", 64'(done_cnt), 64'(want));
  endtask

  task automatic fill_const(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < N_MAX; i++) begin
      mem_a[i] = a;
      mem_b[i] = b;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N_MAX; i++) begin
      case ($urandom_range(0, 5))
        0:       mem_a[i] = 32'h8000_0000;
        1:       mem_a[i] = 32'h7FFF_FFFF;
        default: mem_a[i] = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       mem_b[i] = 32'h8000_0000;
        1:       mem_b[i] = 32'h7FFF_FFFF;
        default: mem_b[i] = $urandom;
      endcase
    end
  endtask

  initial begin
    int d1, d2, d3;
    longint s1, s2, s3;
    int rl;

    bus.start = 1'b0;
    bus.len   = '0;
    fill_const(32'h0, 32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_sad", 64'(bus.sad), 64'd0);
    check("reset_addr", 64'(bus.rom_addr), 64'd0);

    // 1: single element
    mem_a[0] = 32'hFFFF_FFB7;
    mem_b[0] = 32'h0000_00D5;
    check("t1_model", 64'(ref_sad(1)), 64'd286);
    pulse_start(1);
    wait_done(done_base + 1, 20);
    check("t1_done_cyc", 64'(done_e - start_e + 1), 64'd4);
    check("t1_sad", 64'(done_sad), 64'd286);

    // 2: mixed signs including the widest single difference
    mem_a[0] = 32'd5;          mem_b[0] = 32'd2;
    mem_a[1] = 32'hFFFF_FFFB;  mem_b[1] = 32'd5;
    mem_a[2] = 32'h7FFF_FFFF;  mem_b[2] = 32'h8000_0000;
    mem_a[3] = 32'd0;          mem_b[3] = 32'd0;
    check("t2_model", 64'(ref_sad(4)), 64'h1_0000_000C);
    pulse_start(4);
    wait_done(done_base + 1, 20);
    check("t2_done_cyc", 64'(done_e - start_e + 1), 64'd7);
    check("t2_sad", 64'(done_sad), 64'h1_0000_000C);

    // 3: full-length worst case
    fill_const(32'h7FFF_FFFF, 32'h8000_0000);
    max_addr = 0;
    pulse_start(256);
    wait_done(done_base + 1, 400);
    check("t3_done_cyc", 64'(done_e - start_e + 1), 64'd259);
    check("t3_sad", 64'(done_sad), 64'hFF_FFFF_FF00);
    check("t3_max_addr", 64'(max_addr), 64'd255);

    // 4: empty run, then oversize length clamps to 256
    pulse_start(0);
    wait_done(done_base + 1, 10);
    check("t4_zero_cyc", 64'(done_e - start_e + 1), 64'd1);
    check("t4_zero_sad", 64'(done_sad), 64'd0);
    max_addr = 0;
    pulse_start(300);
    wait_done(done_base + 1, 400);
    check("t4_clamp_cyc", 64'(done_e - start_e + 1), 64'd259);
    check("t4_clamp_sad", 64'(done_sad), 64'hFF_FFFF_FF00);
    check("t4_max_addr", 64'(max_addr), 64'd255);

    // 5: reset in RUN cycle 10, then a clean single-element run
    fill_random();
    pulse_start(20);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy", 64'(bus.busy), 64'd0);
    check("t5_done", 64'(bus.done), 64'd0);
    check("t5_sad", 64'(bus.sad), 64'd0);
    check("t5_addr", 64'(bus.rom_addr), 64'd0);
    pulse_start(1);
    wait_done(done_base + 1, 20);
    check("t5_sad_after", 64'(done_sad), 64'(ref_sad(1)));

    // 6: start during RUN is ignored; held start restarts every L+4 cycles
    fill_random();
    pulse_start(5);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = 9'd2;
    @(negedge clk);
    bus.start = 1'b0;
    bus.len   = 9'd5;
    @(negedge clk);
    bus.start = 1'b1;
    wait_done(done_base + 1, 40);
    d1 = done_e; s1 = done_sad;
    wait_done(done_base + 2, 40);
    d2 = done_e; s2 = done_sad;
    wait_done(done_base + 3, 40);
    d3 = done_e; s3 = done_sad;
    bus.start = 1'b0;
    check("t6_first_cyc", 64'(d1 - start_e + 1), 64'd8);
    check("t6_gap1", 64'(d2 - d1), 64'd9);
    check("t6_gap2", 64'(d3 - d2), 64'd9);
    check("t6_sad1", 64'(s1), 64'(ref_sad(5)));
    check("t6_sad2", 64'(s2), 64'(s1));
    check("t6_sad3", 64'(s3), 64'(s1));
    repeat (20) @(negedge clk);

    // Random runs, idle gaps and data, all checked by the compare process.
    for (int r = 0; r < 10; r++) begin
      fill_random();
      rl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 300));
      pulse_start(rl);
      wait_done(done_base + 1, 400);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", ecnt);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sad_engine.md
Name: sad_engine

Overview:
- Reader/consumer for the dual-output SAD test ROM. The ROM returns vector A at `addr` and vector B at `addr+256`, combinationally.
- On `start`, the block walks `rom_addr` from 0 to len-1. It computes the sum of |A[i]-B[i]| over signed 32-bit elements and reports the result with a one-cycle `done` pulse.
- It sits between a control source (testbench or MIPS coprocessor port) and the ROM. It is the datapath that verifies the ROM image end to end.

Parameters:
- `N_MAX`, 256, maximum element count; equals the B-vector offset in the ROM.
- `ADDR_W`, 9, ROM address width.
- `DATA_W`, 32, element width, signed two's complement.
- `ACC_W`, 40, accumulator width; must be ≥ DATA_W + log2(N_MAX).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a SAD run; sampled only in IDLE.
- `len`  in  9  element count; sampled with `start`. 0 = empty run; values >256 are clamped to 256.
- `rom_addr`  out  ADDR_W  ROM address; only 0..N_MAX-1 is ever driven.
- `rom_data_a`  in  DATA_W  ROM dataA; combinational from `rom_addr`, same cycle.
- `rom_data_b`  in  DATA_W  ROM dataB; combinational from `rom_addr`, same cycle.
- `busy`  out  1  high in every state other than IDLE.
- `done`  out  1  one-cycle pulse; `sad` is valid in that cycle.
- `sad`  out  ACC_W  result; held until the next accepted `start` or `rst`.

Behaviour:
- Reset (sync, rst=1 at a rising edge): state=IDLE, `rom_addr`=0, `busy`=0, `done`=0, `sad`=0, accumulator=0, all pipeline valid bits cleared.
- Reset mid-run has the same effect: the run is aborted, no `done` is produced and `sad` reads 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: `start`=1 latches L=min(len,256) and clears the accumulator. Goes to RUN if L>0, else to DONE.
  - RUN: drives `rom_addr`=idx, with idx counting 0..L-1, one address per cycle. When idx=L-1, goes to DRAIN.
  - DRAIN: exactly 2 cycles, which empty the pipeline, then DONE.
  - DONE: `done`=1 and `sad`=accumulator for one cycle, then IDLE.
- Pipeline, 3 registered stages:
  - S1 captures A, B and valid at the end of each RUN cycle.
  - S2 computes d = A - B sign-extended to DATA_W+1 bits and registers |d| as a DATA_W-bit unsigned value. The maximum 2^32-1 fits exactly; no saturation.
  - S3 adds the zero-extended |d| into the ACC_W-bit accumulator when S2 is valid.
- Latency: with `start` sampled at edge 0, RUN occupies cycles 1..L, DRAIN cycles L+1..L+2, and `done` is high in cycle L+3. With L=0, `done` is high in cycle 1 and `sad`=0.
- `busy` is high from cycle 1 through the DONE cycle inclusive.
- `start` while `busy`=1 is ignored. `start` held high continuously restarts in the IDLE cycle after each DONE.
- `sad` holds its value in IDLE. It is updated only in the DONE cycle; `rst` forces it to 0.
- `rom_addr` returns to 0 outside RUN.
- `len` and ROM data are don't-care outside their sampling windows.

Decomposition:
- `sad_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - localparams `N_MAX`, `ADDR_W`, `DATA_W`, `ACC_W`;
  - the DRAIN length constant (2).
- One sub-module, `sad_absdiff`: registered S2 stage with inputs a, b, valid_in and outputs absdiff, valid_out, plus `clk`/`rst`. It is reused in future parallel-lane variants.
- FSM, address counter, S1 and the accumulator stay in `sad_engine`.

Test Plan:
1. L=1, A[0]=-73 (0xFFFFFFB7), B[0]=213 (0xD5) -> `rom_addr`=0 in cycle 1, `done` in cycle 4, `sad`=286.
2. L=4, A={5,-5,0x7FFFFFFF,0}, B={2,5,0x80000000,0} -> `sad`=4294967308 (0x1_0000000C), `done` in cycle 7, `busy` high cycles 1..7.
3. L=256, all A=0x7FFFFFFF, all B=0x80000000 -> `sad`=0xFF_FFFFFF00; `rom_addr` sweeps 0..255; `done` in cycle 259.
4. `len`=0 -> `done` in cycle 1, `sad`=0. `len`=300 -> behaves exactly as 256 (`done` in cycle 259, last `rom_addr`=255).
5. `rst`=1 in RUN cycle 10 -> next cycle: `busy`=0, `done`=0, `sad`=0, `rom_addr`=0. A following L=1 run gives the correct result with no residue.
6. `start` pulsed at RUN cycle 3 (ignored), then held high -> `done` pulses spaced L+4 cycles apart; `sad` identical for each run.
